// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the 2:1 round-robin channel arbiter.
// State codes are fixed so the spare code 2'b11 is a known value.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } arb_state_e;

  localparam logic LAST_RST = 1'b1;

  function automatic arb_state_e grant_state(input logic idx);
    return idx ? G1 : G0;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2to1_w.sv
// Width-parameterised 2:1 data mux.
// Purely combinational; select comes from the arbiter.
module mux2to1_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic             s,
  output logic [WIDTH-1:0] f
);

  assign f = s ? w1 : w0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux channel with a hold limit.
// Grants are Moore outputs of the registered state.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             valid,
  output logic [WIDTH-1:0] f
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          hold_max;

  assign hold_max = (cnt_q == CMAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)
          state_d = grant_state(~last_q);
        else if (req0)
          state_d = G0;
        else if (req1)
          state_d = G1;
      end
      G0: begin
        if (req0 && !(req1 && hold_max))
          state_d = G0;
        else if (req1)
          state_d = G1;
        else
          state_d = IDLE;
      end
      G1: begin
        if (req1 && !(req0 && hold_max))
          state_d = G1;
        else if (req0)
          state_d = G0;
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    sel_d  = sel_q;
    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (state_d != state_q) begin
      cnt_d  = CW'(1);
      last_d = (state_d == G1);
      sel_d  = (state_d == G1);
    end else if (!hold_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt0  = (state_q == G0);
  assign gnt1  = (state_q == G1);
  assign valid = gnt0 | gnt1;
  assign sel   = sel_q;

  mux2to1_w #(.WIDTH(WIDTH)) u_mux (
    .w0(d0),
    .w1(d1),
    .s (sel_q),
    .f (f)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed plan plus random traffic
// against an owner/run-length model, MAX_HOLD=4 and MAX_HOLD=1.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] d0, d1;
  logic       ga0, ga1, sa, va;
  logic       gb0, gb1, sb, vb;
  logic [7:0] fa, fb;

  int npass  = 0;
  int ntotal = 0;

  int mown[2];
  int mrun[2];
  int mlast[2];
  int msel[2];
  int mh[2] = '{4, 1};

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .d0(d0), .d1(d1), .gnt0(ga0), .gnt1(ga1),
    .sel(sa), .valid(va), .f(fa)
  );

  mux2_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .d0(d0), .d1(d1), .gnt0(gb0), .gnt1(gb1),
    .sel(sb), .valid(vb), .f(fb)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    ntotal++;
    assert (o === e) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mown[k]  = -1;
      mrun[k]  = 0;
      mlast[k] = 1;
      msel[k]  = 0;
    end
  endtask

  // Owner -1 means nobody holds the channel.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int   nw;
      logic mine, oth;
      if (rst) begin
        mown[k] = -1; mrun[k] = 0; mlast[k] = 1; msel[k] = 0;
      end else begin
        if (mown[k] < 0) begin
          if (req0 && req1) nw = 1 - mlast[k];
          else if (req0)    nw = 0;
          else if (req1)    nw = 1;
          else              nw = -1;
        end else begin
          mine = (mown[k] == 1) ? req1 : req0;
          oth  = (mown[k] == 1) ? req0 : req1;
          if (mine && !(oth && mrun[k] >= mh[k])) nw = mown[k];
          else if (oth) nw = 1 - mown[k];
          else          nw = -1;
        end
        if (nw < 0) mrun[k] = 0;
        else if (nw == mown[k])
          mrun[k] = (mrun[k] + 1 > mh[k]) ? mh[k] : mrun[k] + 1;
        else begin
          mrun[k]  = 1;
          mlast[k] = nw;
        end
        if (nw >= 0) msel[k] = nw;
        mown[k] = nw;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ef;
    ef = msel[0] ? d1 : d0;
    chk({tag, ".a.gnt0"}, ga0, mown[0] == 0);
    chk({tag, ".a.gnt1"}, ga1, mown[0] == 1);
    chk({tag, ".a.valid"}, va, mown[0] >= 0);
    chk({tag, ".a.sel"}, sa, msel[0] == 1);
    chk({tag, ".a.f"}, fa, ef);
    ef = msel[1] ? d1 : d0;
    chk({tag, ".b.gnt0"}, gb0, mown[1] == 0);
    chk({tag, ".b.gnt1"}, gb1, mown[1] == 1);
    chk({tag, ".b.valid"}, vb, mown[1] >= 0);
    chk({tag, ".b.sel"}, sb, msel[1] == 1);
    chk({tag, ".b.f"}, fb, ef);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    d0 = 8'h3C; d1 = 8'hC3;
    model_reset();
    step("rst");
    step("rst");
    chk("rst_valid", va, 0);
    chk("rst_f", fa, 8'h3C);
    rst = 1'b0;
    repeat (5) step("idle");
    chk("idle_f", fa, 8'h3C);

    req0 = 1'b1; d0 = 8'hA5;
    step("single");
    chk("single_gnt0", ga0, 1);
    chk("single_f", fa, 8'hA5);
    for (int i = 0; i < 10; i++) begin
      step("single_hold");
      chk("single_hold_gnt0", ga0, 1);
    end
    req0 = 1'b0;
    step("release");

    rst = 1'b1;
    step("tie_rst");
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    step("tie");
    chk("tie_first_gnt0", ga0, 1);
    req0 = 1'b0; req1 = 1'b0;
    step("gap");
    step("gap");
    req0 = 1'b1; req1 = 1'b1;
    step("tie2");
    chk("tie_last_gnt1", ga1, 1);

    rst = 1'b1;
    step("hold_rst");
    rst = 1'b0; d0 = 8'h11; d1 = 8'h22;
    for (int i = 0; i < 16; i++) begin
      step("hold");
      chk("hold4_gnt0", ga0, ((i / 4) % 2) == 0);
      chk("hold4_f", fa, (((i / 4) % 2) == 0) ? 8'h11 : 8'h22);
      chk("hold1_gnt0", gb0, (i % 2) == 0);
      chk("hold_excl", ga0 & ga1, 0);
    end

    req1 = 1'b0;
    step("to_g0");
    step("in_g0");
    chk("in_g0_gnt0", ga0, 1);
    req0 = 1'b0; req1 = 1'b1;
    step("handoff");
    chk("handoff_gnt1", ga1, 1);
    chk("handoff_valid", va, 1);
    chk("handoff_f", fa, 8'h22);

    #2 rst = 1'b1;
    #1;
    chk("async_gnt1", ga1, 0);
    chk("async_valid", va, 0);
    chk("async_sel", sa, 0);
    model_reset();
    check_all("async");
    step("async_hold");
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    step("post_async");
    chk("post_async_gnt0", ga0, 1);

    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      step("rand");
      chk("rand_excl", ga0 & ga1, 0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
